// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: mode encodings, default word width
// and the frame-level state type.
package spi_pkg;

    // Each mode is encoded as {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the last two synchronised samples.
module spi_sync_edge #(
    parameter int stages      = 2,
    parameter bit reset_value = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [stages-1:0] sync;
    logic              prev;

    // Resetting to the pin's idle level keeps reset release from looking like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {stages{reset_value}};
            prev <= reset_value;
        end else begin
            sync <= {sync[stages-2:0], pin};
            prev <= sync[stages-1];
        end
    end

    assign level = sync[stages-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversamples CS/SCLK/MOSI with clk, assembles received words and
// serialises a single-entry TX buffer onto MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter bit cpol        = 1'b1,
    parameter bit cpha        = 1'b1,
    parameter int data_width  = DEFAULT_DATA_WIDTH,
    parameter int sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [data_width-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [data_width-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int cnt_width = $clog2(data_width + 1);

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.stages(sync_stages), .reset_value(1'b1)) cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_cs),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.stages(sync_stages), .reset_value(cpol)) sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.stages(sync_stages), .reset_value(1'b0)) mosi_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    spi_state_t state, state_next;
    logic start, stop, do_sample, do_shift, do_load;

    logic [cnt_width-1:0]  bit_cnt;
    logic                  load_pending;
    logic                  word_done;
    logic [data_width-1:0] rx_shift;
    logic [data_width-1:0] tx_shift;
    logic [data_width-1:0] tx_buf;
    logic                  tx_full;
    logic                  last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A CS edge always wins; SCLK edges in the same cycle are dropped.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign do_load  = (start && !cpha) || (do_shift && load_pending);
    assign last_bit = (bit_cnt == cnt_width'(data_width - 1));

    // Receive side: the completed word is published one cycle after its last sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            word_done    <= 1'b0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            word_done <= 1'b0;
            rx_valid  <= word_done;
            if (word_done) begin
                rx_data <= rx_shift;
            end
            if (start || stop) begin
                bit_cnt      <= '0;
                load_pending <= start && cpha;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[data_width-2:0], mosi_level};
                if (last_bit) begin
                    bit_cnt      <= '0;
                    word_done    <= 1'b1;
                    load_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (do_shift && load_pending) begin
                load_pending <= 1'b0;
            end
        end
    end

    // Transmit side: a write in the same cycle as a load refills the buffer after the load.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
            spi_miso    <= 1'b0;
        end else begin
            tx_underrun <= do_load && !tx_full;
            if (do_load) begin
                tx_shift <= tx_full ? tx_buf : '0;
                tx_full  <= 1'b0;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[data_width-2:0], 1'b0};
            end
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            spi_miso <= (state == ACTIVE) && tx_shift[data_width-1];
        end
    end

    assign tx_ready = !tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one mode-3 and one mode-0 target driven by a
// behavioural SPI master, with received words checked by per-target monitors.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs       [2];
    logic         sclk     [2];
    logic         mosi     [2];
    logic         miso     [2];
    logic [W-1:0] tx_data  [2];
    logic         tx_valid [2];
    logic         tx_ready [2];
    logic [W-1:0] rx_data  [2];
    logic         rx_valid [2];
    logic         tx_underrun [2];

    int compared   = 0;
    int mismatched = 0;
    int ucnt0      = 0;
    int ucnt1      = 0;

    logic [W-1:0] rx_exp0[$];
    logic [W-1:0] rx_exp1[$];
    logic [W-1:0] got;
    logic [W-1:0] got2;

    always #5 clk = ~clk;

    spi_slave #(.cpol(MODE3[1]), .cpha(MODE3[0]), .data_width(W), .sync_stages(2)) dut_m3 (
        .clk         (clk),
        .reset       (reset),
        .spi_cs      (cs[0]),
        .spi_sclk    (sclk[0]),
        .spi_mosi    (mosi[0]),
        .spi_miso    (miso[0]),
        .tx_data     (tx_data[0]),
        .tx_valid    (tx_valid[0]),
        .tx_ready    (tx_ready[0]),
        .rx_data     (rx_data[0]),
        .rx_valid    (rx_valid[0]),
        .tx_underrun (tx_underrun[0])
    );

    spi_slave #(.cpol(MODE0[1]), .cpha(MODE0[0]), .data_width(W), .sync_stages(2)) dut_m0 (
        .clk         (clk),
        .reset       (reset),
        .spi_cs      (cs[1]),
        .spi_sclk    (sclk[1]),
        .spi_mosi    (mosi[1]),
        .spi_miso    (miso[1]),
        .tx_data     (tx_data[1]),
        .tx_valid    (tx_valid[1]),
        .tx_ready    (tx_ready[1]),
        .rx_data     (rx_data[1]),
        .rx_valid    (rx_valid[1]),
        .tx_underrun (tx_underrun[1])
    );

    function automatic logic inst_cpol(input int i);
        return (i == 0) ? MODE3[1] : MODE0[1];
    endfunction

    function automatic logic inst_cpha(input int i);
        return (i == 0) ? MODE3[0] : MODE0[0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors: every rx_valid cycle must consume exactly one expected word.
    always @(negedge clk) begin
        if (rx_valid[0]) begin
            if (rx_exp0.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rx0_spurious: rx_valid with data 0x%0h, no word expected", rx_data[0]);
            end else begin
                checkOutput("rx0_word", rx_data[0], rx_exp0.pop_front());
            end
        end
        if (tx_underrun[0]) ucnt0++;
    end

    always @(negedge clk) begin
        if (rx_valid[1]) begin
            if (rx_exp1.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rx1_spurious: rx_valid with data 0x%0h, no word expected", rx_data[1]);
            end else begin
                checkOutput("rx1_word", rx_data[1], rx_exp1.pop_front());
            end
        end
        if (tx_underrun[1]) ucnt1++;
    end

    task automatic half_period();
        repeat (10) @(negedge clk);
    endtask

    task automatic tx_write(input int i, input logic [W-1:0] d);
        int waited;
        waited = 0;
        while (!tx_ready[i] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("tx_ready_wait", tx_ready[i], 1);
        if (tx_ready[i]) begin
            tx_data[i]  = d;
            tx_valid[i] = 1'b1;
            @(negedge clk);
            tx_valid[i] = 1'b0;
        end
    endtask

    task automatic cs_low(input int i);
        cs[i] = 1'b0;
        if (inst_cpha(i)) half_period();
    endtask

    task automatic cs_high(input int i);
        half_period();
        cs[i]   = 1'b1;
        sclk[i] = inst_cpol(i);
        half_period();
        half_period();
    endtask

    // Behavioural master: drives nbits of a word MSB first, captures MISO on sample edges.
    task automatic spi_word(input int i, input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
        logic cp;
        cp = inst_cpol(i);
        rx = '0;
        for (int b = W - 1; b >= W - nbits; b--) begin
            if (!inst_cpha(i)) begin
                mosi[i] = tx[b];
                half_period();
                sclk[i] = ~cp;
                rx[b]   = miso[i];
                half_period();
                sclk[i] = cp;
            end else begin
                sclk[i] = ~cp;
                mosi[i] = tx[b];
                half_period();
                sclk[i] = cp;
                rx[b]   = miso[i];
                half_period();
            end
        end
    endtask

    task automatic applyStimulus(input int i, input string name, input logic [W-1:0] mosi_word,
                                 input logic [W-1:0] exp_miso);
        logic [W-1:0] rx;
        if (i == 0) rx_exp0.push_back(mosi_word);
        else rx_exp1.push_back(mosi_word);
        spi_word(i, mosi_word, W, rx);
        checkOutput(name, rx, exp_miso);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cs[i]       = 1'b1;
            sclk[i]     = inst_cpol(i);
            mosi[i]     = 1'b0;
            tx_data[i]  = '0;
            tx_valid[i] = 1'b0;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_miso", miso[0], 0);
        checkOutput("reset_rx_data", rx_data[0], 0);
        checkOutput("reset_rx_valid", rx_valid[0], 0);
        checkOutput("reset_underrun", tx_underrun[0], 0);
        checkOutput("reset_tx_ready", tx_ready[0], 1);

        $display("[TB] mode 3 single word");
        tx_write(0, 8'hA5);
        cs_low(0);
        applyStimulus(0, "m3_miso_A5", 8'hFA, 8'hA5);
        cs_high(0);
        checkOutput("m3_rx_data", rx_data[0], 8'hFA);
        checkOutput("m3_no_underrun", ucnt0, 0);

        $display("[TB] mode 0 single word");
        tx_write(1, 8'h3C);
        cs_low(1);
        applyStimulus(1, "m0_miso_3C", 8'h81, 8'h3C);
        cs_high(1);
        checkOutput("m0_rx_data", rx_data[1], 8'h81);
        checkOutput("m0_tail_underrun", ucnt1, 1);

        $display("[TB] back-to-back words");
        tx_write(0, 8'h11);
        rx_exp0.push_back(8'hF8);
        rx_exp0.push_back(8'h07);
        cs_low(0);
        fork
            begin
                spi_word(0, 8'hF8, W, got);
                spi_word(0, 8'h07, W, got2);
            end
            tx_write(0, 8'h22);
        join
        cs_high(0);
        checkOutput("b2b_miso_first", got, 8'h11);
        checkOutput("b2b_miso_second", got2, 8'h22);

        $display("[TB] underrun");
        cs_low(0);
        applyStimulus(0, "underrun_miso_zero", 8'hC6, 8'h00);
        cs_high(0);
        checkOutput("underrun_count", ucnt0, 1);

        $display("[TB] CS abort after four bits");
        tx_write(0, 8'h77);
        cs_low(0);
        fork
            spi_word(0, 8'hF0, 4, got);
            tx_write(0, 8'h99);
        join
        cs_high(0);
        checkOutput("abort_rx_hold", rx_data[0], 8'hC6);
        cs_low(0);
        applyStimulus(0, "after_abort_miso", 8'h5A, 8'h99);
        cs_high(0);
        checkOutput("after_abort_rx", rx_data[0], 8'h5A);

        $display("[TB] reset mid-word");
        tx_write(0, 8'hC3);
        cs_low(0);
        spi_word(0, 8'hFF, 2, got);
        tx_write(0, 8'h3A);
        checkOutput("pre_reset_miso", miso[0], 1);
        reset   = 1'b1;
        cs[0]   = 1'b1;
        sclk[0] = inst_cpol(0);
        @(negedge clk);
        checkOutput("midreset_miso", miso[0], 0);
        checkOutput("midreset_rx_data", rx_data[0], 0);
        checkOutput("midreset_rx_valid", rx_valid[0], 0);
        checkOutput("midreset_underrun", tx_underrun[0], 0);
        checkOutput("midreset_tx_ready", tx_ready[0], 1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        tx_write(0, 8'h4B);
        cs_low(0);
        applyStimulus(0, "post_reset_miso", 8'hB4, 8'h4B);
        cs_high(0);
        checkOutput("post_reset_rx", rx_data[0], 8'hB4);

        checkOutput("rx0_pending", rx_exp0.size(), 0);
        checkOutput("rx1_pending", rx_exp1.size(), 0);
        checkOutput("final_underrun0", ucnt0, 1);
        checkOutput("final_underrun1", ucnt1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
